dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, number of 16-bit words stored.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (0 legal).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  1  memory-stage request strobe; sampled only in IDLE.
REQ-006 we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  input  16  byte address; word index = addr[15:1].
REQ-008 wdata  input  16  write data; sampled with req.
REQ-009 rdata  output  16  read data; valid when ready=1 and err=0 on a read.
REQ-010 ready  output  1  one-cycle response strobe closing each accepted request.
REQ-011 err  output  1  error flag; meaningful only while ready=1.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 In IDLE with req=1 at a rising edge, the block SHALL latch we, addr and wdata and go to WAIT if WAIT_CYCLES>0, else to RESP.
REQ-015 In IDLE with req=0, the block SHALL stay in IDLE.
REQ-016 In WAIT, a down-counter loaded with WAIT_CYCLES-1 on entry SHALL decrement each cycle; at zero the FSM SHALL go to RESP.
REQ-017 In RESP, ready SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-018 Latency: req high in cycle n (IDLE) SHALL give ready=1 in cycle n+1+WAIT_CYCLES.
REQ-019 req, we, addr and wdata SHALL be ignored outside IDLE; a request held high through RESP is re-accepted in the following IDLE cycle, so minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-020 Deasserting req during WAIT SHALL NOT cancel the transaction.
REQ-021 The request is in error if the latched addr[0]=1 (misaligned) or the latched addr[15:1] >= DEPTH_WORDS (out of range).
REQ-022 For an in-error request, err SHALL be 1 during RESP, memory SHALL NOT be written, and rdata SHALL hold its previous value.
REQ-023 A valid write SHALL commit wdata to the word on the edge entering RESP; err=0 in RESP; rdata unchanged.
REQ-024 For a valid read, rdata SHALL be loaded on the edge entering RESP and SHALL hold that value until the next valid read response.
REQ-025 A read following a write to the same word SHALL return the written data.
REQ-026 ready and err SHALL be 0 in every cycle other than RESP.

Reset
REQ-027 With rst=1 at a rising edge, the FSM SHALL go to IDLE, the wait counter SHALL be cleared, and rdata SHALL be 0x0000; ready, err and busy SHALL then be 0.
REQ-028 rst SHALL take priority over every other input, including req in the same cycle.
REQ-029 Reset during WAIT SHALL abort the transaction with no memory write and no ready pulse.
REQ-030 Memory array contents SHALL NOT be cleared by reset; a write committed before reset SHALL persist.

Verification (DEPTH_WORDS=256, WAIT_CYCLES=2)
REQ-031 Reset 2 cycles -> ready=0, err=0, busy=0, rdata=0x0000.
REQ-032 Write 0x1234 to addr 0x0010 in cycle n -> busy in n+1..n+3, ready=1 and err=0 only in n+3; then read 0x0010 -> rdata=0x1234 with ready 3 cycles after accept.
REQ-033 Write 0x5678 to 0x0020, then read 0x0010 -> rdata=0x1234; read 0x0020 -> rdata=0x5678.
REQ-034 Write to misaligned 0x0011 -> ready=1 and err=1 in the same cycle; a following read of 0x0010 returns 0x1234.
REQ-035 Read of 0x0200 (word 256) -> ready=1, err=1, rdata holds its prior value.
REQ-036 Write 0xBEEF to 0x0030, with rst pulsed in the first WAIT cycle -> no ready pulse, busy=0 after reset; a read of 0x0030 returns its pre-write value.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per request, inserts WAIT_CYCLES
// wait states, then pulses ready for one cycle with err flagging bad addresses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ready,
   output logic        err,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int CNT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
   localparam int IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [1:0]       state;
   logic [CNT_W-1:0] waitCnt;
   logic             weQ;
   logic [15:0]      addrQ;
   logic [15:0]      wdataQ;
   logic [15:0]      mem [DEPTH_WORDS];

   logic             curWe;
   logic [15:0]      curAddr;
   logic [15:0]      curWdata;
   logic             badAddr;
   logic             enterResp;
   logic [IDX_W-1:0] memIdx;

   // With zero wait states the commit edge is the accept edge, so the live
   // inputs must be used instead of the not-yet-latched copies.
   always_comb begin
      curWe     = (state == IDLE) ? we    : weQ;
      curAddr   = (state == IDLE) ? addr  : addrQ;
      curWdata  = (state == IDLE) ? wdata : wdataQ;
      badAddr   = curAddr[0] || ({17'b0, curAddr[15:1]} >= DEPTH_WORDS);
      memIdx    = curAddr[IDX_W:1];
      enterResp = ((state == WAIT) && (waitCnt == '0)) ||
                  ((state == IDLE) && req && (WAIT_CYCLES == 0));
   end

   assign ready = (state == RESP);
   assign err   = ready && badAddr;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         waitCnt <= '0;
         rdata   <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  if (WAIT_CYCLES > 0) begin
                     state   <= WAIT;
                     waitCnt <= CNT_W'(CNT_LOAD);
                  end else begin
                     state <= RESP;
                  end
               end
            end
            WAIT: begin
               if (waitCnt == '0) state <= RESP;
               else               waitCnt <= waitCnt - 1'b1;
            end
            default: state <= IDLE;
         endcase
         if (enterResp && !curWe && !badAddr) rdata <= mem[memIdx];
      end
   end

   always_ff @(posedge clk) begin
      if ((state == IDLE) && req) begin
         weQ    <= we;
         addrQ  <= addr;
         wdataQ <= wdata;
      end
   end

   // Array is deliberately outside the reset domain; only the commit is gated.
   always_ff @(posedge clk) begin
      if (!rst && enterResp && curWe && !badAddr) mem[memIdx] <= curWdata;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst, req, we;
   logic [15:0] addr, wdata, rdata;
   logic        ready, err, busy;

   int checks   = 0;
   int failures = 0;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .ready(ready), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [15:0] a;
      logic [15:0] d;
      logic        e;
      logic [15:0] r;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1 of an IDLE cycle; leaves at posedge+1 of the next IDLE cycle.
   task automatic txn(input vec_t v, input string tag);
      req = 1'b1; we = v.w; addr = v.a; wdata = v.d;
      tick();
      req = 1'b0; we = ~v.w; addr = 16'hFFFF; wdata = 16'hDEAD;
      for (int c = 1; c <= 3; c++) begin
         chk($sformatf("%s busy c%0d", tag, c), {15'b0, busy}, 16'd1);
         chk($sformatf("%s ready c%0d", tag, c), {15'b0, ready}, (c == 3) ? 16'd1 : 16'd0);
         if (c == 3) begin
            chk($sformatf("%s err", tag), {15'b0, err}, {15'b0, v.e});
            chk($sformatf("%s rdata", tag), rdata, v.r);
         end else begin
            chk($sformatf("%s err c%0d", tag, c), {15'b0, err}, 16'd0);
         end
         tick();
      end
      chk($sformatf("%s idle busy", tag), {15'b0, busy}, 16'd0);
      chk($sformatf("%s idle ready", tag), {15'b0, ready}, 16'd0);
   endtask

   initial begin
      logic [7:0] readyPat;
      int         readySeen;
      vec_t       rv;

      vecs[0]  = '{1'b1, 16'h0010, 16'h1234, 1'b0, 16'h0000};
      vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};
      vecs[2]  = '{1'b1, 16'h0020, 16'h5678, 1'b0, 16'h1234};
      vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};
      vecs[4]  = '{1'b0, 16'h0020, 16'h0000, 1'b0, 16'h5678};
      vecs[5]  = '{1'b1, 16'h0011, 16'h9999, 1'b1, 16'h5678};
      vecs[6]  = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};
      vecs[7]  = '{1'b0, 16'h0200, 16'h0000, 1'b1, 16'h1234};
      vecs[8]  = '{1'b1, 16'h01FE, 16'hA5A5, 1'b0, 16'h1234};
      vecs[9]  = '{1'b0, 16'h01FE, 16'h0000, 1'b0, 16'hA5A5};
      vecs[10] = '{1'b0, 16'h0001, 16'h0000, 1'b1, 16'hA5A5};
      vecs[11] = '{1'b1, 16'h0030, 16'h1111, 1'b0, 16'hA5A5};

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 16'h0000; wdata = 16'h0000;
      tick();
      tick();
      rst = 1'b0;
      chk("reset ready", {15'b0, ready}, 16'd0);
      chk("reset err",   {15'b0, err},   16'd0);
      chk("reset busy",  {15'b0, busy},  16'd0);
      chk("reset rdata", rdata, 16'h0000);

      for (int i = 0; i < 12; i++) txn(vecs[i], $sformatf("v%0d", i));

      // Request held high: re-accepted right after RESP, ready every 4 cycles.
      req = 1'b1; we = 1'b0; addr = 16'h0020; wdata = 16'h0000;
      readyPat = '0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         readyPat[k-1] = ready;
         if (k == 7) req = 1'b0;
      end
      chk("held ready pattern", {8'b0, readyPat}, 16'h0044);
      chk("held rdata", rdata, 16'h5678);
      chk("held idle busy", {15'b0, busy}, 16'd0);

      // Reset in the first WAIT cycle aborts the write.
      req = 1'b1; we = 1'b1; addr = 16'h0030; wdata = 16'hBEEF;
      tick();
      req = 1'b0;
      chk("abort busy in wait", {15'b0, busy}, 16'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort busy", {15'b0, busy}, 16'd0);
      chk("abort rdata", rdata, 16'h0000);
      readySeen = 0;
      for (int k = 0; k < 5; k++) begin
         if (ready) readySeen++;
         tick();
      end
      chk("abort no ready", 16'(readySeen), 16'd0);
      rv = '{1'b0, 16'h0030, 16'h0000, 1'b0, 16'h1111};
      txn(rv, "abort readback");
      rv = '{1'b0, 16'h0010, 16'h0000, 1'b0, 16'h1234};
      txn(rv, "persist readback");

      // Reset wins over a simultaneous request.
      rst = 1'b1; req = 1'b1; we = 1'b1; addr = 16'h0010; wdata = 16'h0BAD;
      tick();
      rst = 1'b0; req = 1'b0;
      chk("rst prio busy", {15'b0, busy}, 16'd0);
      tick();
      chk("rst prio busy2", {15'b0, busy}, 16'd0);
      chk("rst prio ready", {15'b0, ready}, 16'd0);
      txn(rv, "rst prio readback");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
